// File: rtl/icache_miss_sequencer.sv
// Miss-path sequencer for the L1 I-cache: one block request at a time with timeout/re-issue,
// stale-response detection, round-robin victim fill, and a full-array flush walk.
module icache_miss_sequencer #(
    parameter int TAG_BITS     = 20,
    parameter int INDEX_BITS   = 6,
    parameter int NUM_WAYS_LOG = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           miss_i,
    input  logic [TAG_BITS+INDEX_BITS-1:0] missAddr_i,
    output logic [TAG_BITS+INDEX_BITS-1:0] ic2memReqAddr_o,
    output logic                           ic2memReqValid_o,
    output logic [NUM_WAYS_LOG-1:0]        ic2memReqWay_o,
    input  logic [TAG_BITS-1:0]            mem2icTag_i,
    input  logic [INDEX_BITS-1:0]          mem2icIndex_i,
    input  logic                           mem2icRespValid_i,
    input  logic                           mem2icInv_i,
    input  logic [INDEX_BITS-1:0]          mem2icInvInd_i,
    output logic                           fillEn_o,
    output logic [NUM_WAYS_LOG-1:0]        fillWay_o,
    output logic [INDEX_BITS-1:0]          fillIndex_o,
    input  logic                           icFlush_i,
    output logic                           flushEn_o,
    output logic [INDEX_BITS-1:0]          flushIndex_o,
    output logic                           icFlushDone_o,
    output logic                           busy_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FILL  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int              CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [INDEX_BITS-1:0] LAST_INDEX = {INDEX_BITS{1'b1}};

    logic [2:0]                    state, next_state;
    logic [TAG_BITS+INDEX_BITS-1:0] lat_addr;
    logic [NUM_WAYS_LOG-1:0]       lat_way;
    logic [NUM_WAYS_LOG-1:0]       victim;
    logic [CW-1:0]                 tcount;
    logic                          stale;
    logic                          pending_flush;
    logic                          resp_match;
    logic                          inv_hit;
    logic                          flush_req;

    assign resp_match = mem2icRespValid_i && ({mem2icTag_i, mem2icIndex_i} == lat_addr);
    assign inv_hit    = mem2icInv_i && (mem2icInvInd_i == lat_addr[INDEX_BITS-1:0]);
    assign flush_req  = icFlush_i || pending_flush;

    assign ic2memReqAddr_o = lat_addr;
    assign ic2memReqWay_o  = lat_way;
    assign fillWay_o       = lat_way;
    assign fillIndex_o     = lat_addr[INDEX_BITS-1:0];

    // A same-cycle invalidation makes the response stale too, so it outranks the fill.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (flush_req)   next_state = S_FLUSH;
                else if (miss_i) next_state = S_REQ;
            end
            S_REQ:  next_state = S_WAIT;
            S_WAIT: begin
                if (resp_match && (stale || inv_hit)) next_state = S_REQ;
                else if (resp_match)                  next_state = S_FILL;
                else if (tcount == TO_LAST)           next_state = S_REQ;
            end
            S_FILL:  next_state = S_IDLE;
            S_FLUSH: if (flushIndex_o == LAST_INDEX) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            lat_addr         <= '0;
            lat_way          <= '0;
            victim           <= '0;
            tcount           <= '0;
            stale            <= 1'b0;
            pending_flush    <= 1'b0;
            ic2memReqValid_o <= 1'b0;
            fillEn_o         <= 1'b0;
            flushEn_o        <= 1'b0;
            flushIndex_o     <= '0;
            icFlushDone_o    <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            state            <= next_state;
            busy_o           <= (next_state != S_IDLE);
            ic2memReqValid_o <= (next_state == S_REQ);
            fillEn_o         <= (next_state == S_FILL);
            flushEn_o        <= (next_state == S_FLUSH);
            icFlushDone_o    <= (next_state == S_DONE);

            if (state == S_IDLE && next_state == S_REQ) begin
                lat_addr <= missAddr_i;
                lat_way  <= victim;
            end

            if (state == S_WAIT) tcount <= tcount + 1'b1;
            else                 tcount <= '0;

            if (state == S_FILL) victim <= victim + 1'b1;

            // Any fresh request supersedes an earlier invalidation of the line.
            if (next_state == S_REQ)               stale <= 1'b0;
            else if (state == S_WAIT && inv_hit)   stale <= 1'b1;

            if (state == S_IDLE && flush_req)
                pending_flush <= 1'b0;
            else if ((state == S_REQ || state == S_WAIT || state == S_FILL) && icFlush_i)
                pending_flush <= 1'b1;

            if (state == S_FLUSH && next_state == S_FLUSH) flushIndex_o <= flushIndex_o + 1'b1;
            else                                           flushIndex_o <= '0;
        end
    end

endmodule

// File: tb/tb_icache_miss_sequencer.sv
// Directed self-checking bench for icache_miss_sequencer (TIMEOUT=8, 64 sets, 4 ways).
module tb_icache_miss_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_i;
    logic [25:0] missAddr_i;
    logic [25:0] ic2memReqAddr_o;
    logic        ic2memReqValid_o;
    logic [1:0]  ic2memReqWay_o;
    logic [19:0] mem2icTag_i;
    logic [5:0]  mem2icIndex_i;
    logic        mem2icRespValid_i;
    logic        mem2icInv_i;
    logic [5:0]  mem2icInvInd_i;
    logic        fillEn_o;
    logic [1:0]  fillWay_o;
    logic [5:0]  fillIndex_o;
    logic        icFlush_i;
    logic        flushEn_o;
    logic [5:0]  flushIndex_o;
    logic        icFlushDone_o;
    logic        busy_o;

    int checks = 0;
    int passes = 0;

    icache_miss_sequencer #(
        .TAG_BITS(20), .INDEX_BITS(6), .NUM_WAYS_LOG(2), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .miss_i(miss_i), .missAddr_i(missAddr_i),
        .ic2memReqAddr_o(ic2memReqAddr_o), .ic2memReqValid_o(ic2memReqValid_o),
        .ic2memReqWay_o(ic2memReqWay_o), .mem2icTag_i(mem2icTag_i),
        .mem2icIndex_i(mem2icIndex_i), .mem2icRespValid_i(mem2icRespValid_i),
        .mem2icInv_i(mem2icInv_i), .mem2icInvInd_i(mem2icInvInd_i),
        .fillEn_o(fillEn_o), .fillWay_o(fillWay_o), .fillIndex_o(fillIndex_o),
        .icFlush_i(icFlush_i), .flushEn_o(flushEn_o), .flushIndex_o(flushIndex_o),
        .icFlushDone_o(icFlushDone_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Drives one miss; the matching response arrives `delay` cycles after the request strobe.
    task automatic run_miss(input logic [25:0] addr, input int delay,
                            output logic req_seen, output logic [1:0] req_way,
                            output logic fill_seen, output logic [1:0] fill_way,
                            output logic [5:0] fill_idx);
        miss_i = 1'b1;
        missAddr_i = addr;
        @(negedge clk);
        req_seen = ic2memReqValid_o;
        req_way  = ic2memReqWay_o;
        miss_i = 1'b0;
        for (int i = 0; i < delay; i++) @(negedge clk);
        mem2icTag_i = addr[25:6];
        mem2icIndex_i = addr[5:0];
        mem2icRespValid_i = 1'b1;
        @(negedge clk);
        mem2icRespValid_i = 1'b0;
        fill_seen = fillEn_o;
        fill_way  = fillWay_o;
        fill_idx  = fillIndex_o;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [46:0] outs;
        reset = 1'b1;
        miss_i = 0; missAddr_i = '0; mem2icTag_i = '0; mem2icIndex_i = '0;
        mem2icRespValid_i = 0; mem2icInv_i = 0; mem2icInvInd_i = '0; icFlush_i = 0;
        repeat (2) @(negedge clk);
        outs = {ic2memReqAddr_o, ic2memReqValid_o, ic2memReqWay_o, fillEn_o, fillWay_o,
                fillIndex_o, flushEn_o, flushIndex_o, icFlushDone_o, busy_o};
        checks++;
        if (outs !== '0) $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
        else passes++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_miss();
        logic rs, fs; logic [1:0] rw, fw; logic [5:0] fi;
        miss_i = 1'b1;
        missAddr_i = {20'h12345, 6'h2A};
        @(negedge clk);
        miss_i = 1'b0;
        checks++;
        if ({ic2memReqValid_o, ic2memReqWay_o, ic2memReqAddr_o} !== {1'b1, 2'd0, 20'h12345, 6'h2A})
            $display("[TB] FAIL basic_req: got v=%b w=%0d a=%h expected v=1 w=0 a=%h",
                     ic2memReqValid_o, ic2memReqWay_o, ic2memReqAddr_o, {20'h12345, 6'h2A});
        else passes++;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if ({ic2memReqValid_o, fillEn_o, busy_o} !== 3'b001)
                $display("[TB] FAIL basic_wait%0d: got req/fill/busy=%b expected 001", i,
                         {ic2memReqValid_o, fillEn_o, busy_o});
            else passes++;
        end
        @(negedge clk);
        mem2icTag_i = 20'h12345; mem2icIndex_i = 6'h2A; mem2icRespValid_i = 1'b1;
        @(negedge clk);
        mem2icRespValid_i = 1'b0;
        checks++;
        if ({fillEn_o, fillWay_o, fillIndex_o} !== {1'b1, 2'd0, 6'h2A})
            $display("[TB] FAIL basic_fill: got en=%b w=%0d i=%h expected en=1 w=0 i=2a",
                     fillEn_o, fillWay_o, fillIndex_o);
        else passes++;
        @(negedge clk);
        checks++;
        if ({busy_o, fillEn_o} !== 2'b00)
            $display("[TB] FAIL basic_idle: got busy/fill=%b expected 00", {busy_o, fillEn_o});
        else passes++;
        run_miss({20'h00001, 6'h03}, 1, rs, rw, fs, fw, fi);
        checks++;
        if ({rs, rw, fs, fw} !== {1'b1, 2'd1, 1'b1, 2'd1})
            $display("[TB] FAIL basic_next_way: got req=%b w=%0d fill=%b fw=%0d expected 1 1 1 1",
                     rs, rw, fs, fw);
        else passes++;
    endtask

    task automatic test_timeout();
        int gap; bit seen;
        miss_i = 1'b1;
        missAddr_i = {20'h0BEEF, 6'h07};
        @(negedge clk);
        miss_i = 1'b0;
        checks++;
        if ({ic2memReqValid_o, ic2memReqWay_o} !== {1'b1, 2'd2})
            $display("[TB] FAIL timeout_first_req: got v=%b w=%0d expected v=1 w=2",
                     ic2memReqValid_o, ic2memReqWay_o);
        else passes++;
        gap = 0; seen = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            if (i == 2) begin
                mem2icTag_i = 20'h0BEEE; mem2icIndex_i = 6'h07; mem2icRespValid_i = 1'b1;
            end
            @(negedge clk);
            mem2icRespValid_i = 1'b0;
            if (fillEn_o) begin
                checks++;
                $display("[TB] FAIL timeout_no_fill: got fillEn=1 at cycle %0d expected 0", i);
            end
            if (ic2memReqValid_o) begin seen = 1; gap = i; end
        end
        checks++;
        if (gap !== 9) $display("[TB] FAIL timeout_refire: got gap %0d expected 9", gap);
        else passes++;
        checks++;
        if ({ic2memReqAddr_o, ic2memReqWay_o} !== {20'h0BEEF, 6'h07, 2'd2})
            $display("[TB] FAIL timeout_reissue: got a=%h w=%0d expected a=%h w=2",
                     ic2memReqAddr_o, ic2memReqWay_o, {20'h0BEEF, 6'h07});
        else passes++;
        @(negedge clk);
        mem2icTag_i = 20'h0BEEF; mem2icIndex_i = 6'h07; mem2icRespValid_i = 1'b1;
        @(negedge clk);
        mem2icRespValid_i = 1'b0;
        checks++;
        if ({fillEn_o, fillWay_o, fillIndex_o} !== {1'b1, 2'd2, 6'h07})
            $display("[TB] FAIL timeout_fill: got en=%b w=%0d i=%h expected en=1 w=2 i=07",
                     fillEn_o, fillWay_o, fillIndex_o);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_stale();
        miss_i = 1'b1;
        missAddr_i = {20'hABCDE, 6'h11};
        @(negedge clk);
        miss_i = 1'b0;
        @(negedge clk);
        mem2icInv_i = 1'b1; mem2icInvInd_i = 6'h11;
        @(negedge clk);
        mem2icInv_i = 1'b0;
        @(negedge clk);
        mem2icTag_i = 20'hABCDE; mem2icIndex_i = 6'h11; mem2icRespValid_i = 1'b1;
        @(negedge clk);
        mem2icRespValid_i = 1'b0;
        checks++;
        if ({fillEn_o, ic2memReqValid_o, ic2memReqAddr_o, ic2memReqWay_o} !==
            {1'b0, 1'b1, 20'hABCDE, 6'h11, 2'd3})
            $display("[TB] FAIL stale_reissue: got fill=%b req=%b a=%h w=%0d expected 0 1 %h 3",
                     fillEn_o, ic2memReqValid_o, ic2memReqAddr_o, ic2memReqWay_o,
                     {20'hABCDE, 6'h11});
        else passes++;
        @(negedge clk);
        mem2icRespValid_i = 1'b1; mem2icInv_i = 1'b1;
        @(negedge clk);
        mem2icRespValid_i = 1'b0; mem2icInv_i = 1'b0;
        checks++;
        if ({fillEn_o, ic2memReqValid_o} !== 2'b01)
            $display("[TB] FAIL stale_same_cycle: got fill/req=%b expected 01",
                     {fillEn_o, ic2memReqValid_o});
        else passes++;
        @(negedge clk);
        mem2icRespValid_i = 1'b1;
        @(negedge clk);
        mem2icRespValid_i = 1'b0;
        checks++;
        if ({fillEn_o, fillWay_o, fillIndex_o} !== {1'b1, 2'd3, 6'h11})
            $display("[TB] FAIL stale_fill: got en=%b w=%0d i=%h expected en=1 w=3 i=11",
                     fillEn_o, fillWay_o, fillIndex_o);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_flush_during_miss();
        int bad_idx;
        miss_i = 1'b1;
        missAddr_i = {20'h55555, 6'h05};
        @(negedge clk);
        miss_i = 1'b0;
        @(negedge clk);
        icFlush_i = 1'b1;
        @(negedge clk);
        icFlush_i = 1'b0;
        mem2icTag_i = 20'h55555; mem2icIndex_i = 6'h05; mem2icRespValid_i = 1'b1;
        @(negedge clk);
        mem2icRespValid_i = 1'b0;
        checks++;
        if ({fillEn_o, fillWay_o, flushEn_o} !== {1'b1, 2'd0, 1'b0})
            $display("[TB] FAIL flush_fill_first: got fill=%b w=%0d flush=%b expected 1 0 0",
                     fillEn_o, fillWay_o, flushEn_o);
        else passes++;
        @(negedge clk);
        checks++;
        if ({busy_o, flushEn_o} !== 2'b00)
            $display("[TB] FAIL flush_idle_gap: got busy/flush=%b expected 00", {busy_o, flushEn_o});
        else passes++;
        bad_idx = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bad_idx < 0 && ({flushEn_o, flushIndex_o, icFlushDone_o} !== {1'b1, 6'(i), 1'b0}))
                bad_idx = i;
        end
        checks++;
        if (bad_idx != -1)
            $display("[TB] FAIL flush_walk: first bad step got %0d expected -1", bad_idx);
        else passes++;
        @(negedge clk);
        checks++;
        if ({icFlushDone_o, flushEn_o, flushIndex_o} !== {1'b1, 1'b0, 6'd0})
            $display("[TB] FAIL flush_done: got done=%b en=%b idx=%0d expected 1 0 0",
                     icFlushDone_o, flushEn_o, flushIndex_o);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({icFlushDone_o, flushEn_o, busy_o} !== 3'b000)
                $display("[TB] FAIL flush_single_done%0d: got done/en/busy=%b expected 000", i,
                         {icFlushDone_o, flushEn_o, busy_o});
            else passes++;
        end
    endtask

    task automatic test_victim_wrap();
        logic rs, fs; logic [1:0] rw, fw; logic [5:0] fi;
        logic [1:0] exp_way;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_way = 2'd0;
        for (int m = 0; m < 5; m++) begin
            run_miss({20'h30000 + 20'(m), 6'(m + 8)}, 2, rs, rw, fs, fw, fi);
            checks++;
            if ({fs, fw, fi} !== {1'b1, exp_way, 6'(m + 8)})
                $display("[TB] FAIL victim_wrap%0d: got fill=%b w=%0d i=%h expected 1 %0d %h",
                         m, fs, fw, fi, exp_way, 6'(m + 8));
            else passes++;
            exp_way = exp_way + 2'd1;
        end
    endtask

    task automatic test_reset_in_flush();
        logic [46:0] outs;
        bit saw_done;
        icFlush_i = 1'b1;
        @(negedge clk);
        icFlush_i = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        checks++;
        if ({flushEn_o, flushIndex_o} !== {1'b1, 6'd20})
            $display("[TB] FAIL rflush_at20: got en=%b idx=%0d expected 1 20", flushEn_o, flushIndex_o);
        else passes++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        outs = {ic2memReqAddr_o, ic2memReqValid_o, ic2memReqWay_o, fillEn_o, fillWay_o,
                fillIndex_o, flushEn_o, flushIndex_o, icFlushDone_o, busy_o};
        checks++;
        if (outs !== '0) $display("[TB] FAIL rflush_outputs: got %h expected 0", outs);
        else passes++;
        saw_done = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (icFlushDone_o || flushEn_o || busy_o) saw_done = 1;
        end
        checks++;
        if (saw_done !== 1'b0)
            $display("[TB] FAIL rflush_quiet: got activity=%b expected 0", saw_done);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic_miss();
        test_timeout();
        test_stale();
        test_flush_during_miss();
        test_victim_wrap();
        test_reset_in_flush();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
